// File: rtl/hall_call_tx.sv
// Hall-call transmitter: debounces six hall buttons, latches pending calls and lamps,
// and offers them round-robin as 3-bit codes over a valid/ready handshake.
module hall_call_tx #(
    parameter int unsigned DEBOUNCE = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [5:0] btn_i,
    output logic [2:0] call_code_o,
    output logic       call_valid_o,
    input  logic       call_ready_i,
    input  logic       clr_valid_i,
    input  logic [2:0] clr_code_i,
    output logic [5:0] lamp_o
);

    typedef enum logic [1:0] {
        IDLE,
        OFFER,
        GAP
    } state_e;

    localparam logic [3:0] DEB = 4'(DEBOUNCE);

    function automatic logic [2:0] code_of(input logic [2:0] idx);
        case (idx)
            3'd0:    code_of = 3'b001;
            3'd1:    code_of = 3'b010;
            3'd2:    code_of = 3'b011;
            3'd3:    code_of = 3'b110;
            3'd4:    code_of = 3'b111;
            3'd5:    code_of = 3'b100;
            default: code_of = 3'b000;
        endcase
    endfunction

    state_e     state_q, state_d;
    logic [3:0] cnt_q [6];
    logic [3:0] cnt_d [6];
    logic [5:0] pending_q, pending_d;
    logic [5:0] sent_q, sent_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] sel_q, sel_d;

    logic [5:0] press;
    logic [5:0] clr_hit;
    logic [5:0] eligible;
    logic       win_found;
    logic [2:0] win_idx;
    logic [3:0] cand;
    logic       xfer;

    // The counter saturates at DEBOUNCE, so a held button fires exactly once until released.
    always_comb begin
        press   = '0;
        clr_hit = '0;
        for (int i = 0; i < 6; i++) begin
            cnt_d[i] = cnt_q[i];
            if (!btn_i[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] != DEB) begin
                cnt_d[i] = cnt_q[i] + 4'd1;
                press[i] = ((cnt_q[i] + 4'd1) == DEB);
            end
            clr_hit[i] = clr_valid_i && (clr_code_i == code_of(3'(i)));
        end
    end

    // Calls being cleared this cycle are masked so IDLE never offers a dying call.
    assign eligible = pending_q & ~sent_q & ~clr_hit;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 5; k >= 0; k--) begin
            cand = {1'b0, ptr_q} + 4'(k);
            if (cand >= 4'd6) begin
                cand = cand - 4'd6;
            end
            if (eligible[cand[2:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[2:0];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        xfer         = 1'b0;
        call_valid_o = 1'b0;
        call_code_o  = 3'b000;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    sel_d   = win_idx;
                    state_d = OFFER;
                end
            end
            OFFER: begin
                call_valid_o = 1'b1;
                call_code_o  = code_of(sel_q);
                if (call_ready_i) begin
                    xfer    = 1'b1;
                    state_d = GAP;
                end else if (clr_hit[sel_q]) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        pending_d = (pending_q | press) & ~clr_hit;
        sent_d    = (sent_q | (xfer ? (6'b000001 << sel_q) : 6'b000000)) & ~clr_hit;
        ptr_d     = ptr_q;
        if (xfer) begin
            ptr_d = (sel_q == 3'd5) ? 3'd0 : sel_q + 3'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            pending_q <= '0;
            sent_q    <= '0;
            ptr_q     <= '0;
            sel_q     <= '0;
            for (int i = 0; i < 6; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            sent_q    <= sent_d;
            ptr_q     <= ptr_d;
            sel_q     <= sel_d;
            for (int i = 0; i < 6; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign lamp_o = pending_q;

endmodule

// File: tb/tb_hall_call_tx.sv
// Directed self-checking bench for hall_call_tx with DEBOUNCE=2.
module tb_hall_call_tx;

    logic       clk;
    logic       rst;
    logic [5:0] btn;
    logic [2:0] call_code;
    logic       call_valid;
    logic       call_ready;
    logic       clr_valid;
    logic [2:0] clr_code;
    logic [5:0] lamp;

    int checks;
    int failures;

    logic [2:0] cap_codes [8];
    int         cap_n;
    int         cap_viol;

    hall_call_tx #(.DEBOUNCE(2)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .btn_i       (btn),
        .call_code_o (call_code),
        .call_valid_o(call_valid),
        .call_ready_i(call_ready),
        .clr_valid_i (clr_valid),
        .clr_code_i  (clr_code),
        .lamp_o      (lamp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst        = 1'b1;
        btn        = '0;
        call_ready = 1'b0;
        clr_valid  = 1'b0;
        clr_code   = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Records the code of each new offer; ready must be high so each offer lasts one cycle.
    task automatic capture_offers(input int cycles);
        logic prev;
        prev     = 1'b0;
        cap_n    = 0;
        cap_viol = 0;
        for (int c = 0; c < cycles; c++) begin
            tick();
            if (call_valid) begin
                if (prev) cap_viol++;
                else if (cap_n < 8) begin
                    cap_codes[cap_n] = call_code;
                    cap_n++;
                end
            end else if (call_code !== 3'b000) begin
                cap_viol++;
            end
            prev = call_valid;
        end
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        btn        = '0;
        call_ready = 1'b0;
        clr_valid  = 1'b0;
        clr_code   = '0;
        tick();
        checks++;
        if (call_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_valid: got %b expected 0", call_valid); end
        checks++;
        if (call_code !== 3'b000) begin failures++; $display("[TB] FAIL rst_code: got %b expected 000", call_code); end
        checks++;
        if (lamp !== 6'b000000) begin failures++; $display("[TB] FAIL rst_lamp: got %b expected 000000", lamp); end
        rst = 1'b0;
        tick();
        checks++;
        if (call_valid !== 1'b0 || lamp !== 6'b000000) begin
            failures++; $display("[TB] FAIL post_rst_idle: got valid=%b lamp=%b expected 0/000000", call_valid, lamp);
        end
    endtask

    task automatic test_single_press();
        reset_dut();
        call_ready = 1'b1;
        btn        = 6'b000100;
        tick();
        checks++;
        if (lamp !== 6'b000000) begin failures++; $display("[TB] FAIL sp_lamp_e0: got %b expected 000000", lamp); end
        tick();
        checks++;
        if (lamp !== 6'b000100) begin failures++; $display("[TB] FAIL sp_lamp_e1: got %b expected 000100", lamp); end
        checks++;
        if (call_valid !== 1'b0) begin failures++; $display("[TB] FAIL sp_valid_e1: got %b expected 0", call_valid); end
        tick();
        btn = 6'b000000;
        checks++;
        if (call_valid !== 1'b1 || call_code !== 3'b011) begin
            failures++; $display("[TB] FAIL sp_offer_e2: got valid=%b code=%b expected 1/011", call_valid, call_code);
        end
        tick();
        checks++;
        if (call_valid !== 1'b0 || call_code !== 3'b000) begin
            failures++; $display("[TB] FAIL sp_gap_e3: got valid=%b code=%b expected 0/000", call_valid, call_code);
        end
        checks++;
        if (lamp !== 6'b000100) begin failures++; $display("[TB] FAIL sp_lamp_held: got %b expected 000100", lamp); end
        tick();
        tick();
        checks++;
        if (call_valid !== 1'b0) begin failures++; $display("[TB] FAIL sp_no_reoffer: got %b expected 0", call_valid); end
        clr_valid = 1'b1;
        clr_code  = 3'b011;
        tick();
        clr_valid = 1'b0;
        clr_code  = 3'b000;
        checks++;
        if (lamp !== 6'b000000) begin failures++; $display("[TB] FAIL sp_clear: got %b expected 000000", lamp); end
    endtask

    task automatic test_glitch();
        reset_dut();
        call_ready = 1'b1;
        btn        = 6'b100000;
        tick();
        btn = 6'b000000;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (lamp !== 6'b000000 || call_valid !== 1'b0) begin
                failures++; $display("[TB] FAIL glitch_c%0d: got lamp=%b valid=%b expected 000000/0", c, lamp, call_valid);
            end
        end
    endtask

    task automatic test_round_robin();
        reset_dut();
        call_ready = 1'b1;
        btn        = 6'b110001;
        tick();
        tick();
        checks++;
        if (lamp !== 6'b110001) begin failures++; $display("[TB] FAIL rr_lamp: got %b expected 110001", lamp); end
        btn = 6'b000000;
        capture_offers(14);
        checks++;
        if (cap_n !== 3) begin failures++; $display("[TB] FAIL rr_count: got %0d expected 3", cap_n); end
        checks++;
        if (cap_codes[0] !== 3'b001) begin failures++; $display("[TB] FAIL rr_first: got %b expected 001", cap_codes[0]); end
        checks++;
        if (cap_codes[1] !== 3'b111) begin failures++; $display("[TB] FAIL rr_second: got %b expected 111", cap_codes[1]); end
        checks++;
        if (cap_codes[2] !== 3'b100) begin failures++; $display("[TB] FAIL rr_third: got %b expected 100", cap_codes[2]); end
        checks++;
        if (cap_viol !== 0) begin failures++; $display("[TB] FAIL rr_gap: got %0d gap violations expected 0", cap_viol); end

        clr_valid = 1'b1;
        clr_code  = 3'b001;
        tick();
        clr_code = 3'b111;
        tick();
        clr_code = 3'b100;
        tick();
        clr_valid = 1'b0;
        clr_code  = 3'b000;
        checks++;
        if (lamp !== 6'b000000) begin failures++; $display("[TB] FAIL rr_cleared: got %b expected 000000", lamp); end

        btn = 6'b000011;
        tick();
        tick();
        btn = 6'b000000;
        capture_offers(12);
        checks++;
        if (cap_n !== 2) begin failures++; $display("[TB] FAIL rr_wrap_count: got %0d expected 2", cap_n); end
        checks++;
        if (cap_codes[0] !== 3'b001) begin failures++; $display("[TB] FAIL rr_wrap_first: got %b expected 001", cap_codes[0]); end
        checks++;
        if (cap_codes[1] !== 3'b010) begin failures++; $display("[TB] FAIL rr_wrap_second: got %b expected 010", cap_codes[1]); end
        checks++;
        if (cap_viol !== 0) begin failures++; $display("[TB] FAIL rr_wrap_gap: got %0d gap violations expected 0", cap_viol); end
    endtask

    task automatic test_backpressure();
        int nvalid;
        reset_dut();
        call_ready = 1'b0;
        btn        = 6'b001000;
        tick();
        tick();
        btn = 6'b000000;
        tick();
        for (int c = 0; c < 7; c++) begin
            checks++;
            if (call_valid !== 1'b1 || call_code !== 3'b110) begin
                failures++; $display("[TB] FAIL bp_hold_c%0d: got valid=%b code=%b expected 1/110", c, call_valid, call_code);
            end
            tick();
        end
        call_ready = 1'b1;
        checks++;
        if (call_valid !== 1'b1 || call_code !== 3'b110) begin
            failures++; $display("[TB] FAIL bp_before_xfer: got valid=%b code=%b expected 1/110", call_valid, call_code);
        end
        tick();
        nvalid = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (call_valid) nvalid++;
        end
        checks++;
        if (nvalid !== 0) begin failures++; $display("[TB] FAIL bp_no_reoffer: got %0d valid cycles expected 0", nvalid); end
        checks++;
        if (lamp !== 6'b001000) begin failures++; $display("[TB] FAIL bp_lamp: got %b expected 001000", lamp); end
    endtask

    task automatic test_clear_during_offer();
        int nvalid;
        reset_dut();
        call_ready = 1'b0;
        btn        = 6'b000100;
        tick();
        tick();
        btn = 6'b000000;
        tick();
        checks++;
        if (call_valid !== 1'b1 || call_code !== 3'b011) begin
            failures++; $display("[TB] FAIL cdo_offer: got valid=%b code=%b expected 1/011", call_valid, call_code);
        end
        clr_valid = 1'b1;
        clr_code  = 3'b011;
        tick();
        clr_valid = 1'b0;
        clr_code  = 3'b000;
        checks++;
        if (call_valid !== 1'b0) begin failures++; $display("[TB] FAIL cdo_withdraw: got %b expected 0", call_valid); end
        checks++;
        if (call_code !== 3'b000) begin failures++; $display("[TB] FAIL cdo_code: got %b expected 000", call_code); end
        checks++;
        if (lamp !== 6'b000000) begin failures++; $display("[TB] FAIL cdo_lamp: got %b expected 000000", lamp); end
        call_ready = 1'b1;
        nvalid     = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (call_valid) nvalid++;
        end
        checks++;
        if (nvalid !== 0) begin failures++; $display("[TB] FAIL cdo_no_reoffer: got %0d valid cycles expected 0", nvalid); end
    endtask

    task automatic test_press_clear_and_reset();
        reset_dut();
        call_ready = 1'b0;
        btn        = 6'b000010;
        tick();
        clr_valid = 1'b1;
        clr_code  = 3'b010;
        tick();
        clr_valid = 1'b0;
        clr_code  = 3'b000;
        checks++;
        if (lamp !== 6'b000000) begin failures++; $display("[TB] FAIL pc_clear_wins: got %b expected 000000", lamp); end
        tick();
        tick();
        checks++;
        if (lamp !== 6'b000000 || call_valid !== 1'b0) begin
            failures++; $display("[TB] FAIL pc_held_no_event: got lamp=%b valid=%b expected 000000/0", lamp, call_valid);
        end
        btn = 6'b000000;
        tick();
        btn = 6'b000010;
        tick();
        tick();
        checks++;
        if (lamp !== 6'b000010) begin failures++; $display("[TB] FAIL pc_repress: got %b expected 000010", lamp); end
        btn = 6'b000000;
        tick();
        checks++;
        if (call_valid !== 1'b1 || call_code !== 3'b010) begin
            failures++; $display("[TB] FAIL pc_offer: got valid=%b code=%b expected 1/010", call_valid, call_code);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (call_valid !== 1'b0 || call_code !== 3'b000 || lamp !== 6'b000000) begin
            failures++; $display("[TB] FAIL async_rst: got valid=%b code=%b lamp=%b expected 0/000/000000", call_valid, call_code, lamp);
        end
        tick();
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if (call_valid !== 1'b0 || lamp !== 6'b000000) begin
            failures++; $display("[TB] FAIL after_rst: got valid=%b lamp=%b expected 0/000000", call_valid, lamp);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single_press();
        test_glitch();
        test_round_robin();
        test_backpressure();
        test_clear_during_offer();
        test_press_clear_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
